rx_word_assembler: RTL and testbench

Assembles a stream of fixed-width symbols from the debug unit's receive path (UART byte plus done strobe) into instruction or command words of configurable width. Symbols can be packed least-significant-first or most-significant-first. A partial word is discarded after a programmable idle timeout. Completed words leave through a valid/ready port with one output holding slot, and symbols that cannot be stored are reported as overflow. It sits between the UART receiver and the debug control FSM / instruction-memory loader.

---
 rtl/debug_pkg.sv | 18 +
 rtl/rx_word_assembler_idle_timer.sv | 32 +++
 rtl/rx_word_assembler.sv | 166 ++++++++++++++++
 tb/tb_rx_word_assembler.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the debug unit: default widths, assembler state
// encoding and the symbol-count width helper.
package debug_pkg;

  localparam int DEBUG_WORD_WIDTH = 32;
  localparam int UART_DATA_WIDTH  = 8;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } asm_state_t;

  // Bits needed to hold a symbol count ranging over 0..n inclusive.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rx_word_assembler_idle_timer.sv
// Idle counter for the word assembler: strobes expire on the cycle the
// enabled count would reach TIMEOUT_CYCLES, then restarts from zero.
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] cnt;

  assign expire = enable && (cnt == TW'(TIMEOUT_CYCLES - 1));

  // Saturating idle count; holds while disabled so a FULL word freezes it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= {TW{1'b0}};
    end else if (clear || expire) begin
      cnt <= {TW{1'b0}};
    end else if (enable && (cnt != TW'(TIMEOUT_CYCLES))) begin
      cnt <= cnt + TW'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/rx_word_assembler.sv
// Packs UART symbols into WORD_WIDTH words with a one-deep output slot,
// overflow reporting, flush and an optional idle timeout.
module rx_word_assembler
  import debug_pkg::*;
#(
  parameter int DATA_WIDTH     = UART_DATA_WIDTH,
  parameter int WORD_WIDTH     = DEBUG_WORD_WIDTH,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int N  = WORD_WIDTH / DATA_WIDTH,
  localparam int CW = count_width(N)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_msb_first,
  input  logic                  i_flush,
  output logic [WORD_WIDTH-1:0] o_word,
  output logic                  o_word_valid,
  input  logic                  i_word_ready,
  output logic                  o_overflow,
  output logic                  o_timeout,
  output logic                  o_busy,
  output logic [CW-1:0]         o_symbol_count
);

  localparam logic [WORD_WIDTH-1:0] ZERO_WORD = {WORD_WIDTH{1'b0}};
  localparam logic [CW-1:0]         ZERO_CNT  = {CW{1'b0}};

  asm_state_t            state, state_n;
  logic [WORD_WIDTH-1:0] asm_reg, asm_n, word_n;
  logic [CW-1:0]         count_n;
  logic                  msb, msb_n, word_valid_n, overflow_n, timeout_n;
  logic                  accept, expire, timer_enable;

  function automatic logic [WORD_WIDTH-1:0] place(
    input logic [WORD_WIDTH-1:0] base,
    input logic [DATA_WIDTH-1:0] sym,
    input logic [CW-1:0]         k,
    input logic                  msb_order
  );
    logic [WORD_WIDTH-1:0] res;
    int slot;
    slot = msb_order ? (N - 1 - int'(k)) : int'(k);
    res = base;
    res[slot*DATA_WIDTH +: DATA_WIDTH] = sym;
    return res;
  endfunction

  assign timer_enable = (state == ST_COLLECT) && (o_symbol_count != ZERO_CNT)
                        && !i_valid && !i_flush;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timer
      idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
        .clk    (i_clk),
        .reset_n(i_reset_n),
        .clear  (i_flush || accept),
        .enable (timer_enable),
        .expire (expire)
      );
    end else begin : g_no_timer
      assign expire = 1'b0;
    end
  endgenerate

  // Next-state: symbol packing, slot hand-off, overflow, timeout and flush.
  always_comb begin
    state_n      = state;
    asm_n        = asm_reg;
    count_n      = o_symbol_count;
    msb_n        = msb;
    word_n       = o_word;
    word_valid_n = o_word_valid && !i_word_ready;
    overflow_n   = 1'b0;
    timeout_n    = 1'b0;
    accept       = 1'b0;
    case (state)
      ST_COLLECT: begin
        if (i_flush) begin
          asm_n   = ZERO_WORD;
          count_n = ZERO_CNT;
        end else if (i_valid) begin
          accept = 1'b1;
          msb_n  = (o_symbol_count == ZERO_CNT) ? i_msb_first : msb;
          asm_n  = place((o_symbol_count == ZERO_CNT) ? ZERO_WORD : asm_reg,
                         i_data, o_symbol_count, msb_n);
          if (o_symbol_count == CW'(N - 1)) begin
            if (!o_word_valid || i_word_ready) begin
              word_n       = asm_n;
              word_valid_n = 1'b1;
              asm_n        = ZERO_WORD;
              count_n      = ZERO_CNT;
            end else begin
              state_n = ST_FULL;
              count_n = CW'(N);
            end
          end else begin
            count_n = o_symbol_count + CW'(1);
          end
        end else if (expire) begin
          asm_n     = ZERO_WORD;
          count_n   = ZERO_CNT;
          timeout_n = 1'b1;
        end else begin
          state_n = ST_COLLECT;
        end
      end
      ST_FULL: begin
        if (i_flush) begin
          state_n = ST_COLLECT;
          asm_n   = ZERO_WORD;
          count_n = ZERO_CNT;
        end else if (i_word_ready) begin
          state_n      = ST_COLLECT;
          word_n       = asm_reg;
          word_valid_n = 1'b1;
          if (i_valid) begin
            accept  = 1'b1;
            msb_n   = i_msb_first;
            asm_n   = place(ZERO_WORD, i_data, ZERO_CNT, i_msb_first);
            count_n = CW'(1);
          end else begin
            asm_n   = ZERO_WORD;
            count_n = ZERO_CNT;
          end
        end else if (i_valid) begin
          overflow_n = 1'b1;
        end else begin
          state_n = ST_FULL;
        end
      end
      default: begin
        state_n = ST_COLLECT;
        asm_n   = ZERO_WORD;
        count_n = ZERO_CNT;
      end
    endcase
  end

  // All state and outputs are registered.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state          <= ST_COLLECT;
      asm_reg        <= ZERO_WORD;
      msb            <= 1'b0;
      o_word         <= ZERO_WORD;
      o_word_valid   <= 1'b0;
      o_overflow     <= 1'b0;
      o_timeout      <= 1'b0;
      o_busy         <= 1'b0;
      o_symbol_count <= ZERO_CNT;
    end else begin
      state          <= state_n;
      asm_reg        <= asm_n;
      msb            <= msb_n;
      o_word         <= word_n;
      o_word_valid   <= word_valid_n;
      o_overflow     <= overflow_n;
      o_timeout      <= timeout_n;
      o_busy         <= (count_n != ZERO_CNT);
      o_symbol_count <= count_n;
    end
  end

endmodule

// File: tb/tb_rx_word_assembler.sv
// Directed bench for rx_word_assembler (8-bit symbols, 32-bit words,
// 10-cycle idle timeout).
module tb_rx_word_assembler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid;
  logic [7:0]  data;
  logic        msb_first;
  logic        flush;
  logic [31:0] word;
  logic        word_valid;
  logic        word_ready;
  logic        overflow;
  logic        timeout;
  logic        busy;
  logic [2:0]  symbol_count;

  int checks = 0;
  int errors = 0;

  rx_word_assembler #(
    .DATA_WIDTH    (8),
    .WORD_WIDTH    (32),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_valid       (valid),
    .i_data        (data),
    .i_msb_first   (msb_first),
    .i_flush       (flush),
    .o_word        (word),
    .o_word_valid  (word_valid),
    .i_word_ready  (word_ready),
    .o_overflow    (overflow),
    .o_timeout     (timeout),
    .o_busy        (busy),
    .o_symbol_count(symbol_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    valid = 1'b1;
    data  = d;
    tick();
    valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; valid = 1'b0; data = 8'h00; msb_first = 1'b0;
    flush = 1'b0; word_ready = 1'b1;
    tick(); tick();
    chk("rst_word", word, 32'h0);
    chk("rst_valid", {31'b0, word_valid}, 32'h0);
    chk("rst_ovf", {31'b0, overflow}, 32'h0);
    chk("rst_to", {31'b0, timeout}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_count", {29'b0, symbol_count}, 32'h0);
    reset_n = 1'b1;
    tick();

    // 1: LSB-first packing, one-cycle latency, one-cycle valid
    send(8'h11); send(8'h22); send(8'h33);
    chk("t1_count3", {29'b0, symbol_count}, 32'h3);
    chk("t1_busy", {31'b0, busy}, 32'h1);
    chk("t1_nvalid", {31'b0, word_valid}, 32'h0);
    send(8'h44);
    chk("t1_word", word, 32'h44332211);
    chk("t1_valid", {31'b0, word_valid}, 32'h1);
    chk("t1_count0", {29'b0, symbol_count}, 32'h0);
    tick();
    chk("t1_valid_drop", {31'b0, word_valid}, 32'h0);
    chk("t1_word_kept", word, 32'h44332211);

    // 2: MSB-first, order latched with symbol 0
    msb_first = 1'b1; send(8'h11);
    msb_first = 1'b0; send(8'h22);
    msb_first = 1'b1; send(8'h33);
    msb_first = 1'b0; send(8'h44);
    chk("t2_word", word, 32'h11223344);
    chk("t2_valid", {31'b0, word_valid}, 32'h1);
    tick();

    // 3: back-pressure, FULL and overflow
    word_ready = 1'b0;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("t3_word1", word, 32'h04030201);
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    chk("t3_full_count", {29'b0, symbol_count}, 32'h4);
    chk("t3_full_busy", {31'b0, busy}, 32'h1);
    chk("t3_held", word, 32'h04030201);
    chk("t3_no_ovf", {31'b0, overflow}, 32'h0);
    send(8'hAA);
    chk("t3_ovf", {31'b0, overflow}, 32'h1);
    tick();
    chk("t3_ovf_pulse", {31'b0, overflow}, 32'h0);
    chk("t3_held2", word, 32'h04030201);
    word_ready = 1'b1;
    tick();
    chk("t3_word2", word, 32'h08070605);
    chk("t3_valid2", {31'b0, word_valid}, 32'h1);
    chk("t3_count0", {29'b0, symbol_count}, 32'h0);
    tick();
    chk("t3_valid_drop", {31'b0, word_valid}, 32'h0);

    // 4: idle timeout after 10 cycles
    send(8'h5A); send(8'h5B);
    for (int i = 0; i < 9; i++) tick();
    chk("t4_pre_count", {29'b0, symbol_count}, 32'h2);
    chk("t4_pre_to", {31'b0, timeout}, 32'h0);
    tick();
    chk("t4_to", {31'b0, timeout}, 32'h1);
    chk("t4_count0", {29'b0, symbol_count}, 32'h0);
    chk("t4_busy0", {31'b0, busy}, 32'h0);
    tick();
    chk("t4_to_pulse", {31'b0, timeout}, 32'h0);
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    chk("t4_word", word, 32'hA4A3A2A1);
    tick();

    // 5: flush with a coincident symbol, then reset mid-word
    send(8'h01); send(8'h02); send(8'h03);
    valid = 1'b1; data = 8'h04; flush = 1'b1;
    tick();
    valid = 1'b0; flush = 1'b0;
    chk("t5_count0", {29'b0, symbol_count}, 32'h0);
    chk("t5_nvalid", {31'b0, word_valid}, 32'h0);
    chk("t5_no_ovf", {31'b0, overflow}, 32'h0);
    chk("t5_busy0", {31'b0, busy}, 32'h0);
    tick();
    chk("t5_nvalid2", {31'b0, word_valid}, 32'h0);
    send(8'h01); send(8'h02);
    reset_n = 1'b0;
    tick();
    chk("t5_rst_word", word, 32'h0);
    chk("t5_rst_count", {29'b0, symbol_count}, 32'h0);
    chk("t5_rst_busy", {31'b0, busy}, 32'h0);
    chk("t5_rst_valid", {31'b0, word_valid}, 32'h0);
    reset_n = 1'b1;
    tick();

    // 6: FULL held past timeout, slot freed together with a new symbol
    word_ready = 1'b0;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t6_frozen_to", {31'b0, timeout}, 32'h0);
    end
    chk("t6_full_count", {29'b0, symbol_count}, 32'h4);
    word_ready = 1'b1; valid = 1'b1; data = 8'h55;
    tick();
    valid = 1'b0;
    chk("t6_word", word, 32'h08070605);
    chk("t6_no_ovf", {31'b0, overflow}, 32'h0);
    chk("t6_count1", {29'b0, symbol_count}, 32'h1);
    send(8'h66);
    chk("t6_no_ovf2", {31'b0, overflow}, 32'h0);
    send(8'h77); send(8'h88);
    chk("t6_word_next", word, 32'h88776655);
    chk("t6_valid", {31'b0, word_valid}, 32'h1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
